id_ex_stage_register: RTL and testbench

//  ID/EX pipeline register of the 5-stage RV32I core. It sits directly upstream of the ALU forwarding unit.
//  It supplies the EX_Rs1/EX_Rs2/EX_Rd, operands and controls that the forwarding unit and ALU consume.

---
 rtl/id_ex_stage_register.sv | 206 ++++++++++++++++++++
 tb/tb_id_ex_stage_register.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// same-cycle WB operand bypass and a saturating load-use stall counter.
module id_ex_stage_register #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ID_valid,
  input  logic [XLEN-1:0]    ID_PC,
  input  logic [XLEN-1:0]    ID_rdata1,
  input  logic [XLEN-1:0]    ID_rdata2,
  input  logic [XLEN-1:0]    ID_imm,
  input  logic [4:0]         ID_Rs1,
  input  logic [4:0]         ID_Rs2,
  input  logic               ID_uses_rs1,
  input  logic               ID_uses_rs2,
  input  logic [4:0]         ID_Rd,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_ALUSrc,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic               flush,
  input  logic               hold,
  input  logic               WB_RegWrite,
  input  logic [4:0]         WB_Rd,
  input  logic [XLEN-1:0]    WB_data,
  output logic               EX_valid,
  output logic [XLEN-1:0]    EX_PC,
  output logic [XLEN-1:0]    EX_rdata1,
  output logic [XLEN-1:0]    EX_rdata2,
  output logic [XLEN-1:0]    EX_imm,
  output logic [4:0]         EX_Rs1,
  output logic [4:0]         EX_Rs2,
  output logic [4:0]         EX_Rd,
  output logic               EX_RegWrite,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_ALUSrc,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic               stall,
  output logic [CNT_W-1:0]   stall_count
);

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2
  } action_t;

  logic               valid_reg,    valid_next;
  logic [XLEN-1:0]    pc_reg,       pc_next;
  logic [XLEN-1:0]    rdata1_reg,   rdata1_next;
  logic [XLEN-1:0]    rdata2_reg,   rdata2_next;
  logic [XLEN-1:0]    imm_reg,      imm_next;
  logic [4:0]         rs1_reg,      rs1_next;
  logic [4:0]         rs2_reg,      rs2_next;
  logic [4:0]         rd_reg,       rd_next;
  logic               regwrite_reg, regwrite_next;
  logic               memread_reg,  memread_next;
  logic               memwrite_reg, memwrite_next;
  logic               alusrc_reg,   alusrc_next;
  logic [ALUOP_W-1:0] aluop_reg,    aluop_next;
  logic [CNT_W-1:0]   count_reg,    count_next;

  logic    rs1_hit;
  logic    rs2_hit;
  logic    lu_hazard;
  logic    wb_fwd1;
  logic    wb_fwd2;
  logic    count_full;
  action_t action;

  // Load-use detection compares the ID sources against the load now in EX.
  always_comb begin
    rs1_hit   = ID_uses_rs1 && (ID_Rs1 == rd_reg);
    rs2_hit   = ID_uses_rs2 && (ID_Rs2 == rd_reg);
    lu_hazard = valid_reg && memread_reg && (rd_reg != 5'd0) && ID_valid &&
                (rs1_hit || rs2_hit);
  end

  // A squashed ID instruction never needs to wait for its operands.
  assign stall = lu_hazard && !flush;

  always_comb begin
    wb_fwd1    = WB_RegWrite && (WB_Rd != 5'd0) && (WB_Rd == ID_Rs1);
    wb_fwd2    = WB_RegWrite && (WB_Rd != 5'd0) && (WB_Rd == ID_Rs2);
    count_full = (count_reg == {CNT_W{1'b1}});
  end

  always_comb begin
    action = ACT_LOAD;
    if (hold) begin
      action = ACT_HOLD;
    end else if (flush || stall) begin
      action = ACT_BUBBLE;
    end
  end

  always_comb begin
    valid_next    = valid_reg;
    pc_next       = pc_reg;
    rdata1_next   = rdata1_reg;
    rdata2_next   = rdata2_reg;
    imm_next      = imm_reg;
    rs1_next      = rs1_reg;
    rs2_next      = rs2_reg;
    rd_next       = rd_reg;
    regwrite_next = regwrite_reg;
    memread_next  = memread_reg;
    memwrite_next = memwrite_reg;
    alusrc_next   = alusrc_reg;
    aluop_next    = aluop_reg;
    count_next    = count_reg;
    case (action)
      ACT_BUBBLE: begin
        valid_next    = 1'b0;
        pc_next       = '0;
        rdata1_next   = '0;
        rdata2_next   = '0;
        imm_next      = '0;
        rs1_next      = '0;
        rs2_next      = '0;
        rd_next       = '0;
        regwrite_next = 1'b0;
        memread_next  = 1'b0;
        memwrite_next = 1'b0;
        alusrc_next   = 1'b0;
        aluop_next    = '0;
        // Flush wins over stall, so only genuine load-use bubbles are counted.
        if (stall && !count_full) begin
          count_next = count_reg + 1'b1;
        end
      end
      ACT_LOAD: begin
        valid_next    = ID_valid;
        pc_next       = ID_PC;
        rdata1_next   = wb_fwd1 ? WB_data : ID_rdata1;
        rdata2_next   = wb_fwd2 ? WB_data : ID_rdata2;
        imm_next      = ID_imm;
        rs1_next      = ID_Rs1;
        rs2_next      = ID_Rs2;
        rd_next       = ID_Rd;
        // A writer to x0 is demoted here so the forwarding unit never sees it.
        regwrite_next = ID_valid && ID_RegWrite && (ID_Rd != 5'd0);
        memread_next  = ID_valid && ID_MemRead;
        memwrite_next = ID_valid && ID_MemWrite;
        alusrc_next   = ID_valid && ID_ALUSrc;
        aluop_next    = ID_valid ? ID_ALUOp : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      rdata1_reg   <= '0;
      rdata2_reg   <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      alusrc_reg   <= 1'b0;
      aluop_reg    <= '0;
      count_reg    <= '0;
    end else begin
      valid_reg    <= valid_next;
      pc_reg       <= pc_next;
      rdata1_reg   <= rdata1_next;
      rdata2_reg   <= rdata2_next;
      imm_reg      <= imm_next;
      rs1_reg      <= rs1_next;
      rs2_reg      <= rs2_next;
      rd_reg       <= rd_next;
      regwrite_reg <= regwrite_next;
      memread_reg  <= memread_next;
      memwrite_reg <= memwrite_next;
      alusrc_reg   <= alusrc_next;
      aluop_reg    <= aluop_next;
      count_reg    <= count_next;
    end
  end

  assign EX_valid    = valid_reg;
  assign EX_PC       = pc_reg;
  assign EX_rdata1   = rdata1_reg;
  assign EX_rdata2   = rdata2_reg;
  assign EX_imm      = imm_reg;
  assign EX_Rs1      = rs1_reg;
  assign EX_Rs2      = rs2_reg;
  assign EX_Rd       = rd_reg;
  assign EX_RegWrite = regwrite_reg;
  assign EX_MemRead  = memread_reg;
  assign EX_MemWrite = memwrite_reg;
  assign EX_ALUSrc   = alusrc_reg;
  assign EX_ALUOp    = aluop_reg;
  assign stall_count = count_reg;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Randomised and directed bench for id_ex_stage_register against a
// behavioural model of the ID/EX register, hazard rule and stall counter.
module tb_id_ex_stage_register;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ID_valid;
  logic [XLEN-1:0]    ID_PC, ID_rdata1, ID_rdata2, ID_imm;
  logic [4:0]         ID_Rs1, ID_Rs2, ID_Rd;
  logic               ID_uses_rs1, ID_uses_rs2;
  logic               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ALUSrc;
  logic [ALUOP_W-1:0] ID_ALUOp;
  logic               flush, hold;
  logic               WB_RegWrite;
  logic [4:0]         WB_Rd;
  logic [XLEN-1:0]    WB_data;
  logic               EX_valid;
  logic [XLEN-1:0]    EX_PC, EX_rdata1, EX_rdata2, EX_imm;
  logic [4:0]         EX_Rs1, EX_Rs2, EX_Rd;
  logic               EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc;
  logic [ALUOP_W-1:0] EX_ALUOp;
  logic               stall;
  logic [CNT_W-1:0]   stall_count;

  id_ex_stage_register #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_PC(ID_PC), .ID_rdata1(ID_rdata1), .ID_rdata2(ID_rdata2),
    .ID_imm(ID_imm), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .ID_Rd(ID_Rd),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
    .flush(flush), .hold(hold),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_data(WB_data),
    .EX_valid(EX_valid), .EX_PC(EX_PC), .EX_rdata1(EX_rdata1), .EX_rdata2(EX_rdata2),
    .EX_imm(EX_imm), .EX_Rs1(EX_Rs1), .EX_Rs2(EX_Rs2), .EX_Rd(EX_Rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_ALUSrc(EX_ALUSrc), .EX_ALUOp(EX_ALUOp),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the EX latch contents and the stall counter.
  typedef struct {
    logic               valid;
    logic [XLEN-1:0]    pc, rd1, rd2, imm;
    logic [4:0]         rs1, rs2, rd;
    logic               rw, mr, mw, alusrc;
    logic [ALUOP_W-1:0] aluop;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;
  logic seen_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic ex_t empty_ex();
    ex_t e;
    e = '{valid: 1'b0, pc: '0, rd1: '0, rd2: '0, imm: '0, rs1: '0, rs2: '0, rd: '0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0, alusrc: 1'b0, aluop: '0};
    return e;
  endfunction

  function automatic logic model_stall();
    logic reads_ld;
    reads_ld = (ID_uses_rs1 && ID_Rs1 == m_ex.rd) || (ID_uses_rs2 && ID_Rs2 == m_ex.rd);
    return m_ex.valid && m_ex.mr && m_ex.rd != 0 && ID_valid && reads_ld && !flush;
  endfunction

  function automatic logic [XLEN-1:0] wb_value(input logic [4:0] src, input logic [XLEN-1:0] rf);
    return (WB_RegWrite && WB_Rd != 0 && WB_Rd == src) ? WB_data : rf;
  endfunction

  task automatic model_edge(input logic st);
    if (hold) return;
    if (flush || st) begin
      m_ex = empty_ex();
      if (st && m_cnt < CNT_MAX) m_cnt++;
      return;
    end
    m_ex.valid  = ID_valid;
    m_ex.pc     = ID_PC;
    m_ex.rd1    = wb_value(ID_Rs1, ID_rdata1);
    m_ex.rd2    = wb_value(ID_Rs2, ID_rdata2);
    m_ex.imm    = ID_imm;
    m_ex.rs1    = ID_Rs1;
    m_ex.rs2    = ID_Rs2;
    m_ex.rd     = ID_Rd;
    m_ex.rw     = ID_valid && ID_RegWrite && ID_Rd != 0;
    m_ex.mr     = ID_valid && ID_MemRead;
    m_ex.mw     = ID_valid && ID_MemWrite;
    m_ex.alusrc = ID_valid && ID_ALUSrc;
    m_ex.aluop  = ID_valid ? ID_ALUOp : '0;
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".EX_valid"},    EX_valid,    m_ex.valid);
    check({ph, ".EX_PC"},       EX_PC,       m_ex.pc);
    check({ph, ".EX_rdata1"},   EX_rdata1,   m_ex.rd1);
    check({ph, ".EX_rdata2"},   EX_rdata2,   m_ex.rd2);
    check({ph, ".EX_imm"},      EX_imm,      m_ex.imm);
    check({ph, ".EX_Rs1"},      EX_Rs1,      m_ex.rs1);
    check({ph, ".EX_Rs2"},      EX_Rs2,      m_ex.rs2);
    check({ph, ".EX_Rd"},       EX_Rd,       m_ex.rd);
    check({ph, ".EX_RegWrite"}, EX_RegWrite, m_ex.rw);
    check({ph, ".EX_MemRead"},  EX_MemRead,  m_ex.mr);
    check({ph, ".EX_MemWrite"}, EX_MemWrite, m_ex.mw);
    check({ph, ".EX_ALUSrc"},   EX_ALUSrc,   m_ex.alusrc);
    check({ph, ".EX_ALUOp"},    EX_ALUOp,    m_ex.aluop);
    check({ph, ".stall_count"}, stall_count, m_cnt);
  endtask

  // Called just after a falling edge with ID/WB/control inputs already set.
  task automatic step(input string ph);
    logic exp_st;
    #1;
    exp_st = model_stall();
    seen_stall = stall;
    check({ph, ".stall"}, stall, exp_st);
    @(posedge clk);
    model_edge(exp_st);
    #1;
    compare_all(ph);
    @(negedge clk);
  endtask

  task automatic id_instr(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2);
    ID_valid = 1'b1;      ID_MemRead = mr;     ID_MemWrite = 1'b0;
    ID_RegWrite = 1'b1;   ID_ALUSrc = mr;      ID_ALUOp = 4'($urandom);
    ID_Rd = rd;           ID_Rs1 = rs1;        ID_Rs2 = rs2;
    ID_uses_rs1 = u1;     ID_uses_rs2 = u2;
    ID_PC = $urandom;     ID_rdata1 = $urandom; ID_rdata2 = $urandom; ID_imm = $urandom;
    flush = 1'b0;         hold = 1'b0;
    WB_RegWrite = 1'b0;   WB_Rd = '0;          WB_data = '0;
  endtask

  task automatic randomize_inputs();
    ID_valid    = ($urandom_range(0, 9) != 0);
    ID_PC       = $urandom;
    ID_rdata1   = $urandom;
    ID_rdata2   = $urandom;
    ID_imm      = $urandom;
    ID_Rs1      = 5'($urandom_range(0, 7));
    ID_Rs2      = 5'($urandom_range(0, 7));
    ID_Rd       = 5'($urandom_range(0, 7));
    ID_uses_rs1 = ($urandom_range(0, 3) != 0);
    ID_uses_rs2 = $urandom_range(0, 1) != 0;
    ID_RegWrite = $urandom_range(0, 1) != 0;
    ID_MemRead  = ($urandom_range(0, 9) < 4);
    ID_MemWrite = $urandom_range(0, 1) != 0;
    ID_ALUSrc   = $urandom_range(0, 1) != 0;
    ID_ALUOp    = 4'($urandom);
    flush       = ($urandom_range(0, 9) == 0);
    hold        = ($urandom_range(0, 9) == 0);
    WB_RegWrite = $urandom_range(0, 1) != 0;
    WB_Rd       = 5'($urandom_range(0, 7));
    WB_data     = $urandom;
  endtask

  task automatic check_outputs_zero(input string ph);
    check({ph, ".EX_valid"},    EX_valid,    0);
    check({ph, ".EX_PC"},       EX_PC,       0);
    check({ph, ".EX_rdata1"},   EX_rdata1,   0);
    check({ph, ".EX_rdata2"},   EX_rdata2,   0);
    check({ph, ".EX_Rd"},       EX_Rd,       0);
    check({ph, ".EX_RegWrite"}, EX_RegWrite, 0);
    check({ph, ".EX_MemRead"},  EX_MemRead,  0);
    check({ph, ".EX_ALUOp"},    EX_ALUOp,    0);
    check({ph, ".stall"},       stall,       0);
    check({ph, ".stall_count"}, stall_count, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ID_valid = 1'b0;
    m_ex = empty_ex();
    m_cnt = 0;
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // lw x5 then add x6,x5,x1: one bubble, then the add enters EX.
    id_instr(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0);
    step("lw_x5");
    id_instr(1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1);
    step("lu_stall");
    check("lu_stall.seen", seen_stall, 1);
    check("lu_stall.bubble", EX_valid, 0);
    check("lu_stall.count", stall_count, 1);
    step("lu_after");
    check("lu_after.stall", seen_stall, 0);
    check("lu_after.valid", EX_valid, 1);
    check("lu_after.rd", EX_Rd, 6);

    // lw x0 followed by a reader of x0: no hazard.
    id_instr(1'b1, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0);
    step("lw_x0");
    check("lw_x0.regwrite", EX_RegWrite, 0);
    id_instr(1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1);
    step("use_x0");
    check("use_x0.stall", seen_stall, 0);
    check("use_x0.valid", EX_valid, 1);
    check("use_x0.count", stall_count, 1);

    // Same-cycle WB bypass, and no bypass for x0.
    id_instr(1'b0, 5'd8, 5'd7, 5'd9, 1'b1, 1'b1);
    ID_rdata1 = '0;
    WB_RegWrite = 1'b1; WB_Rd = 5'd7; WB_data = 32'hDEADBEEF;
    step("wb_byp");
    check("wb_byp.rdata1", EX_rdata1, 32'hDEADBEEF);
    id_instr(1'b0, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1);
    ID_rdata1 = '0;
    WB_RegWrite = 1'b1; WB_Rd = 5'd0; WB_data = 32'hDEADBEEF;
    step("wb_x0");
    check("wb_x0.rdata1", EX_rdata1, 0);

    // Load-use hazard coinciding with flush.
    id_instr(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0);
    step("lw_fl");
    id_instr(1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1);
    flush = 1'b1;
    step("lu_flush");
    check("lu_flush.stall", seen_stall, 0);
    check("lu_flush.valid", EX_valid, 0);
    check("lu_flush.count", stall_count, 1);

    // Hold for three cycles while a stall is pending.
    id_instr(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0);
    step("lw_hold");
    id_instr(1'b0, 5'd6, 5'd0, 5'd5, 1'b0, 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check("hold.valid", EX_valid, 1);
      check("hold.rd", EX_Rd, 5);
      check("hold.count", stall_count, 1);
    end
    hold = 1'b0;
    step("hold_rel");
    check("hold_rel.bubble", EX_valid, 0);
    check("hold_rel.count", stall_count, 2);

    // 20 load-use pairs: counter saturates at all-ones.
    for (int i = 0; i < 20; i++) begin
      id_instr(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0);
      step("sat_lw");
      id_instr(1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1);
      step("sat_use");
      step("sat_go");
    end
    check("sat.count", stall_count, CNT_MAX);

    // Randomised traffic, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rand");
    end
    id_instr(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0);
    step("pre_rst");
    id_instr(1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    m_ex = empty_ex();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    randomize_inputs();
    step("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
